audio_out_stage: RTL

AUDIO_OUT_STAGE -- requirements
Module: audio_out_stage

---
 rtl/audio_out_stage_if.sv | 29 ++
 rtl/audio_out_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/audio_out_stage_if.sv
// Output-side stream of the audio output stage: FIFO head, handshake and status.
// master = producer (audio_out_stage), slave = sample consumer.
interface audio_out_stage_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic [LW-1:0] level;

    modport master (
        output out_data,
        output out_valid,
        output overrun,
        output level,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  overrun,
        input  level,
        output out_ready
    );
endinterface

// File: rtl/audio_out_stage.sv
// Audio output stage: 64-sample boxcar decimator, DC blocker, attenuation/mute
// and a small output FIFO with sticky overrun.
module audio_out_stage #(
    parameter int DEPTH    = 4,
    parameter int DC_SHIFT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_3MHz_en,
    input  logic         clk_48KHz_en,
    input  logic [15:0]  in,
    input  logic         mute,
    input  logic [3:0]   atten,
    audio_out_stage_if.master aout
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [21:0]        acc;
    logic [6:0]         cnt;
    logic [15:0]        avg;
    logic               avg_valid;
    logic signed [16:0] x;
    logic               x_valid;
    logic signed [16:0] x_prev;
    logic signed [15:0] y_prev;

    logic signed [19:0] x_ext;
    logic signed [19:0] x_prev_ext;
    logic signed [19:0] y_prev_ext;
    logic signed [19:0] y_leak_ext;
    logic signed [19:0] y_full;
    logic signed [15:0] y_sat;
    logic signed [15:0] s;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          overrun;
    logic          full;
    logic          pop;
    logic          do_push;

    // Window accumulator; a strobe coincident with the tick opens the next window.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= clk_48KHz_en;
            if (clk_48KHz_en) begin
                avg <= acc[21:6];
                if (clk_3MHz_en) begin
                    acc <= {6'd0, in};
                    cnt <= 7'd1;
                end else begin
                    acc <= '0;
                    cnt <= '0;
                end
            end else if (clk_3MHz_en && cnt != 7'd64) begin
                acc <= acc + {6'd0, in};
                cnt <= cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            x_valid <= 1'b0;
        end else begin
            x       <= $signed({1'b0, avg}) - 17'sd32768;
            x_valid <= avg_valid;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        x_ext      = x;
        x_prev_ext = x_prev;
        y_prev_ext = y_prev;
        y_leak_ext = y_prev >>> DC_SHIFT;
        y_full     = x_ext - x_prev_ext + y_prev_ext - y_leak_ext;
        y_sat      = y_full[15:0];
        if (y_full > 20'sd32767) begin
            y_sat = 16'sh7fff;
        end else if (y_full < -20'sd32768) begin
            y_sat = 16'sh8000;
        end
        s = mute ? 16'sd0 : (y_sat >>> atten);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (x_valid) begin
            x_prev <= x;
            y_prev <= y_sat;
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign full    = (level == LW'(DEPTH));
    assign pop     = (level != '0) && aout.out_ready;
    assign do_push = x_valid && (!full || pop);

    // NOTE: sample storage carries no reset; level gates out_valid, so stale
    // entries are never presented as valid data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !do_push) begin
                level <= level - 1'b1;
            end
            if (x_valid && full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign aout.out_data  = mem[rd_ptr];
    assign aout.out_valid = (level != '0);
    assign aout.level     = level;
    assign aout.overrun   = overrun;
endmodule
